spi_rx_frame_buffer: RTL

Receive-side buffer directly downstream of `spi_slave`. It watches the SPI chip-select line, detects the end of each frame, and captures the slave's parallel word `o_getdata` into a first-word-fall-through FIFO. The FIFO presents the captured word to the system side through a valid/ready handshake. The block decouples SPI frame arrival from consumer timing and reports dropped frames.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_cs_sync.sv | 31 +++
 rtl/spi_rx_frame_buffer.sv | 94 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Constants shared by the SPI master, slave and the receive/transmit side buffers.
package spi_pkg;

    localparam int unsigned SPI_DATA_W  = 16;
    localparam logic        SPI_CS_IDLE = 1'b1;

endpackage

// File: rtl/spi_cs_sync.sv
// Synchronizes the asynchronous SPI chip select into sys_clk and flags its rising edge (frame end).
module spi_cs_sync
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_cs,
    output logic o_cs_sync,
    output logic o_cs_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cs_prev;

    // Everything resets to idle so releasing reset never looks like a frame end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q  <= {SYNC_STAGES{SPI_CS_IDLE}};
            cs_prev <= SPI_CS_IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_cs};
            cs_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_cs_sync = sync_q[SYNC_STAGES-1];
    assign o_cs_rise = o_cs_sync & ~cs_prev;

endmodule

// File: rtl/spi_rx_frame_buffer.sv
// Captures the SPI slave's word at each frame end into a first-word-fall-through FIFO
// with valid/ready output, sticky overflow flag and a frame counter.
module spi_rx_frame_buffer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       i_cs,
    input  logic [DATA_W-1:0]          i_getdata,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    input  logic                       i_clr_overflow,
    output logic [15:0]                o_frame_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              cs_sync;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_acc;
    logic              drop;

    spi_cs_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cs_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_cs      (i_cs),
        .o_cs_sync (cs_sync),
        .o_cs_rise (push)
    );

    assign full     = (level == LVL_W'(DEPTH));
    assign o_valid  = (level != '0);
    assign pop      = o_valid & i_ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO still fits.
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;

    always_ff @(posedge sys_clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= i_getdata;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                o_overflow <= 1'b0;
            end
            if (push) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset, so the head is masked to keep o_data at zero while empty.
    assign o_data  = o_valid ? mem[rd_ptr] : '0;
    assign o_level = level;

endmodule
